// File: rtl/pwm_demod_pkg.sv
// ---------------------------------------------------------------------------
// pwm_demod_pkg
//   Shared type definitions for the PWM demodulator.
//   Contents:
//     state_e : measurement FSM states
//               IDLE  - after reset, waiting for the first rising edge
//               MEAS  - measuring high time and period between rising edges
//               STUCK - line declared stuck, waiting for activity to resume
// ---------------------------------------------------------------------------
package pwm_demod_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MEAS  = 2'd1,
      STUCK = 2'd2
   } state_e;

endpackage : pwm_demod_pkg

// File: rtl/pwm_demod_if.sv
// ---------------------------------------------------------------------------
// pwm_demod_if
//   Bundles the PWM stream input and the measurement result outputs of
//   pwm_demod.
//   Parameters:
//     PERIOD  : nominal PWM period in clk cycles, N = clog2(PERIOD)
//     TIMEOUT : cycles without a rising edge before the line is stuck,
//               W = clog2(TIMEOUT+1)
//   Signals:
//     in_i    : PWM stream (may be asynchronous to clk)
//     out_o   : N-bit measured high time, saturated at 2^N-1
//     per_o   : W-bit measured period, 0 when stuck
//     valid_o : one-cycle strobe, out_o/per_o/stuck_o updated this cycle
//     stuck_o : no rising edge within TIMEOUT; level is encoded in out_o
//   Modports:
//     master : stream source / result consumer
//     slave  : the demodulator
// ---------------------------------------------------------------------------
interface pwm_demod_if #(
   parameter int PERIOD  = 16,
   parameter int TIMEOUT = 2 * PERIOD
);
   localparam int N = $clog2(PERIOD);
   localparam int W = $clog2(TIMEOUT + 1);

   logic         in_i;
   logic [N-1:0] out_o;
   logic [W-1:0] per_o;
   logic         valid_o;
   logic         stuck_o;

   modport master (
      output in_i,
      input  out_o, per_o, valid_o, stuck_o
   );

   modport slave (
      input  in_i,
      output out_o, per_o, valid_o, stuck_o
   );

endinterface : pwm_demod_if

// File: rtl/pwm_demod_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//   Two-flop synchronizer followed by a rising-edge detector. Reusable by any
//   input-capture block that samples an asynchronous pin.
//   Ports:
//     clk     : sampling clock, all logic on posedge
//     rst     : synchronous, active-high reset (clears all flops)
//     d_i     : asynchronous input
//     level_o : synchronized level (second synchronizer stage)
//     rise_o  : combinational, high for one cycle after level_o goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q;     // first stage, may go metastable
   logic sync_q;     // second stage, safe to use
   logic sync_dly_q; // previous synchronized level, for edge detect

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of its source and the three stages
   // form a real shift chain instead of collapsing into one flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q     <= 1'b0;
         sync_q     <= 1'b0;
         sync_dly_q <= 1'b0;
      end else begin
         meta_q     <= d_i;
         sync_q     <= meta_q;
         sync_dly_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~sync_dly_q;

endmodule : sync_edge

// File: rtl/pwm_demod.sv
// ---------------------------------------------------------------------------
// pwm_demod
//   PWM demodulator, receive-side counterpart of the pwm modulator. Samples a
//   PWM stream, measures high time and period between rising edges and
//   presents the duty in the modulator's N-bit format. A line with no rising
//   edge for TIMEOUT cycles is reported as stuck, with its level in out.
//   Parameters:
//     PERIOD  : nominal PWM period in clk cycles, N = clog2(PERIOD)
//     TIMEOUT : clk cycles without a rising edge before the line is stuck
//   Ports:
//     clk       : sampling clock, all logic on posedge
//     rst       : synchronous, active-high reset, highest priority
//     bus.in_i  : PWM stream, may be asynchronous to clk
//     bus.out_o : measured high time, saturated at 2^N-1
//     bus.per_o : measured period, 0 when stuck
//     bus.valid_o : one-cycle strobe, results updated this cycle
//     bus.stuck_o : no rising edge within TIMEOUT
//   Latency: a pin edge produces the valid strobe 3 clk later (2 sync stages
//   plus the result register).
// ---------------------------------------------------------------------------
`ifndef _PWM_DEMOD_V_
`define _PWM_DEMOD_V_

module pwm_demod
   import pwm_demod_pkg::*;
#(
   parameter int PERIOD  = 16,
   parameter int TIMEOUT = 2 * PERIOD
) (
   input  logic           clk,
   input  logic           rst,
   pwm_demod_if.slave     bus
);

   localparam int N       = $clog2(PERIOD);
   localparam int W       = $clog2(TIMEOUT + 1);
   localparam int SAT_MAX = (2 ** N) - 1;

   localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
   localparam logic [W-1:0] SAT_W     = W'(SAT_MAX);
   localparam logic [W-1:0] ONE_W     = W'(1);
   localparam logic [N-1:0] SAT_N     = N'(SAT_MAX);

   logic level;
   logic rise;

   state_e       state_q;
   logic [W-1:0] pcnt_q, pcnt_d;
   logic [W-1:0] hcnt_q, hcnt_d;
   logic [N-1:0] out_q,  out_d;
   logic [W-1:0] per_q;
   logic         valid_q;
   logic         stuck_q;

   sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (bus.in_i),
      .level_o (level),
      .rise_o  (rise)
   );

   // Saturating increments and the clipped high time. Counters stop at
   // TIMEOUT so they can never wrap back into a plausible-looking value.
   // NOTE: every signal assigned in an always_comb is given a value on every
   // path (here unconditionally), otherwise synthesis infers a latch.
   always_comb begin
      pcnt_d = (pcnt_q == TIMEOUT_W) ? TIMEOUT_W : pcnt_q + ONE_W;
      hcnt_d = (hcnt_q == TIMEOUT_W) ? TIMEOUT_W : hcnt_q + ONE_W;
      out_d  = (hcnt_q > SAT_W) ? SAT_N : hcnt_q[N-1:0];
   end

   // Measurement FSM with registered results. The rising-edge cycle itself is
   // the first cycle of the new period and the first high cycle, hence the
   // restart value of 1 for both counters. A rise always beats the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pcnt_q  <= '0;
         hcnt_q  <= '0;
         out_q   <= '0;
         per_q   <= '0;
         valid_q <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // No period reference yet: levels are ignored, only the
               // elapsed time is tracked so a dead line is still reported.
               if (rise) begin
                  pcnt_q  <= ONE_W;
                  hcnt_q  <= ONE_W;
                  state_q <= MEAS;
               end else if (pcnt_q == TIMEOUT_W) begin
                  out_q   <= level ? SAT_N : '0;
                  per_q   <= '0;
                  stuck_q <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= STUCK;
               end else begin
                  pcnt_q  <= pcnt_d;
               end
            end

            MEAS: begin
               if (rise) begin
                  out_q   <= out_d;
                  per_q   <= pcnt_q;
                  stuck_q <= 1'b0;
                  valid_q <= 1'b1;
                  pcnt_q  <= ONE_W;
                  hcnt_q  <= ONE_W;
               end else if (pcnt_q == TIMEOUT_W) begin
                  out_q   <= level ? SAT_N : '0;
                  per_q   <= '0;
                  stuck_q <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= STUCK;
               end else begin
                  pcnt_q  <= pcnt_d;
                  if (level) begin
                     hcnt_q <= hcnt_d;
                  end
               end
            end

            STUCK: begin
               // The first period after recovery is incomplete, so it starts
               // a measurement but makes no report; stuck stays set until then.
               if (rise) begin
                  pcnt_q  <= ONE_W;
                  hcnt_q  <= ONE_W;
                  state_q <= MEAS;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_o   = out_q;
   assign bus.per_o   = per_q;
   assign bus.valid_o = valid_q;
   assign bus.stuck_o = stuck_q;

endmodule : pwm_demod

`endif // _PWM_DEMOD_V_

// File: tb/tb_pwm_demod.sv
// ---------------------------------------------------------------------------
// tb_pwm_demod
//   Self-checking bench for pwm_demod (PERIOD=16, TIMEOUT=32).
//   The pin waveform of each segment is built first; a reference model then
//   derives the expected result stream from that waveform by looking at the
//   synchronized level sequence, the positions of its rising edges, the gaps
//   between them and the sum of high samples inside each gap. The segment is
//   then driven and every cycle's outputs are compared with the model.
// ---------------------------------------------------------------------------
module tb_pwm_demod;

   localparam int PERIOD  = 16;
   localparam int TIMEOUT = 32;
   localparam int SAT     = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pwm_demod_if #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) bus ();

   pwm_demod #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   bit pins[$];   // pin value driven in each cycle of the current segment
   bit ev[$];     // expected valid per cycle
   int eo[$];     // expected out per cycle (held between reports)
   int ep[$];     // expected per per cycle
   bit es[$];     // expected stuck per cycle

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   // Append nper periods of a PWM wave starting at phase 'phase'.
   task automatic add_pwm(input int period, input int duty, input int nper,
                          input int phase);
      for (int k = 0; k < period * nper; k++)
         pins.push_back(((k + phase) % period) < duty);
   endtask

   task automatic add_level(input bit lvl, input int ncyc);
      for (int k = 0; k < ncyc; k++) pins.push_back(lvl);
   endtask

   // Reference model. The FSM in cycle j sees the pin value driven two
   // cycles earlier (zero right after reset). Reports:
   //  - a rise while measuring: per = distance to the previous rise,
   //    out = number of high samples in between (clipped to SAT);
   //  - TIMEOUT cycles since the last rise (or since reset) with no rise:
   //    stuck report, out = current level ? SAT : 0, per = 0;
   //  - the first rise after reset or after a stuck report only starts a
   //    measurement. Results hold between reports.
   task automatic build_model();
      bit s[$];
      int mode;    // 0 waiting for first rise, 1 measuring, 2 stuck
      int anchor;  // cycle of the last rise (or of reset)
      int ho, hp, hi;
      bit hs, v, prev, rise;
      ev.delete(); eo.delete(); ep.delete(); es.delete();
      for (int j = 0; j < pins.size(); j++) begin
         if (j >= 2) s.push_back(pins[j-2]);
         else        s.push_back(1'b0);
      end
      mode = 0; anchor = 0; ho = 0; hp = 0; hs = 1'b0;
      for (int j = 0; j < s.size(); j++) begin
         v    = 1'b0;
         prev = (j > 0) ? s[j-1] : 1'b0;
         rise = s[j] & ~prev;
         if (rise) begin
            if (mode == 1) begin
               hi = 0;
               for (int k = anchor; k < j; k++) hi += int'(s[k]);
               ho = (hi > SAT) ? SAT : hi;
               hp = j - anchor;
               hs = 1'b0;
               v  = 1'b1;
            end
            mode   = 1;
            anchor = j;
         end else if (mode != 2 && (j - anchor) >= TIMEOUT) begin
            ho   = s[j] ? SAT : 0;
            hp   = 0;
            hs   = 1'b1;
            v    = 1'b1;
            mode = 2;
         end
         ev.push_back(v);
         eo.push_back(ho);
         ep.push_back(hp);
         es.push_back(hs);
      end
   endtask

   // Reset for ncyc cycles with the pin toggling; results must stay cleared.
   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         bus.in_i = i[0];
         @(posedge clk); #1;
         check("rst_valid", 32'(bus.valid_o), 32'd0);
         check("rst_out",   32'(bus.out_o),   32'd0);
         check("rst_per",   32'(bus.per_o),   32'd0);
         check("rst_stuck", 32'(bus.stuck_o), 32'd0);
      end
      rst = 1'b0;
   endtask

   // Drive the built waveform and compare every cycle against the model.
   task automatic run_segment(input string name);
      int n_valid;
      build_model();
      n_valid = 0;
      for (int j = 0; j < pins.size(); j++) begin
         bus.in_i = pins[j];
         @(posedge clk); #1;
         check({name, "_valid"}, 32'(bus.valid_o), 32'(ev[j]));
         check({name, "_out"},   32'(bus.out_o),   32'(eo[j]));
         check({name, "_per"},   32'(bus.per_o),   32'(ep[j]));
         check({name, "_stuck"}, 32'(bus.stuck_o), 32'(es[j]));
         if (ev[j]) n_valid++;
      end
      $display("segment %s: %0d cycles, %0d expected reports", name,
               pins.size(), n_valid);
      pins.delete();
   endtask

   initial begin
      int per_r, duty_r, len_r;
      bus.in_i = 1'b0;

      // 1: long reset with toggling input
      do_reset(40);

      // 2: steady 5/16 stream, reports every 16 clk from the 2nd rise
      add_pwm(16, 5, 6, 0);
      run_segment("duty5");

      // 3: line held low, single stuck report with out=0
      do_reset(1);
      add_level(1'b0, 80);
      run_segment("stuck_lo");

      // 4: line held high, then 3/16 stream
      do_reset(1);
      add_level(1'b1, 50);
      add_pwm(16, 3, 4, 0);
      run_segment("stuck_hi");

      // 5: duty switches 5 -> 12 mid-stream
      do_reset(1);
      add_pwm(16, 5, 3, 0);
      add_pwm(16, 12, 3, 0);
      run_segment("duty_chg");

      // 6: 20 high / 6 low saturates out; reset pulsed mid-period
      do_reset(1);
      add_pwm(26, 20, 3, 0);
      add_pwm(26, 20, 1, 0);
      pins = pins[0:26*3+9];
      run_segment("sat26");
      do_reset(1);
      add_pwm(26, 20, 3, 10);
      run_segment("sat26_rst");

      // boundaries: rise exactly at the timeout, and one cycle past it
      do_reset(1);
      add_pwm(32, 10, 4, 0);
      run_segment("per32");
      do_reset(1);
      add_pwm(33, 10, 4, 0);
      run_segment("per33");

      // randomized PWM streams
      for (int r = 0; r < 8; r++) begin
         do_reset(1);
         per_r  = int'($urandom_range(3, 40));
         duty_r = int'($urandom_range(1, per_r - 1));
         add_pwm(per_r, duty_r, int'($urandom_range(2, 5)),
                 int'($urandom_range(0, per_r - 1)));
         per_r  = int'($urandom_range(3, 24));
         duty_r = int'($urandom_range(1, per_r - 1));
         add_pwm(per_r, duty_r, int'($urandom_range(2, 4)), 0);
         run_segment("rand_pwm");
      end

      // randomized runs of levels, covering stuck and recovery mid-stream
      do_reset(1);
      for (int r = 0; r < 40; r++) begin
         len_r = int'($urandom_range(1, 40));
         add_level(r[0], len_r);
      end
      run_segment("rand_lvl");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pwm_demod
